// File: rtl/lr_car_queue.sv
// lr_car_queue: local-road car queue that drives LR_has_Car into the light controller
// and releases queued cars one every DEPART_GAP green cycles.
module lr_car_queue #(
  parameter int DEPTH      = 7,
  parameter int CNT_W      = 3,
  parameter int DEPART_GAP = 2
) (
  input  logic             CLK,
  input  logic             RESET_n,
  input  logic             car_arrive,
  input  logic [2:0]       LR_light,
  input  logic [2:0]       HW_light,
  output logic             LR_has_Car,
  output logic [CNT_W-1:0] queue_cnt,
  output logic             depart,
  output logic             overflow,
  output logic             violation
);
  localparam int GAP_W = DEPART_GAP > 1 ? $clog2(DEPART_GAP) : 1;
  localparam logic [2:0] GREEN  = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b001;
  typedef enum logic [1:0] {EMPTY, WAITING, FLOWING} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [GAP_W-1:0] r_gap;
  logic             r_depart;
  logic             r_overflow;
  logic             r_violation;
  logic             w_green;
  logic             w_busy;
  logic             w_dep;
  logic             w_full;
  logic             w_lr_ok;
  logic             w_hw_ok;
  logic             w_drop;
  logic [CNT_W-1:0] w_cnt_nxt;
  always_comb begin
    w_green   = LR_light == GREEN;
    // state is EMPTY exactly when the registered count is zero
    w_busy    = w_green && r_state != EMPTY;
    w_dep     = w_busy && r_gap == GAP_W'(DEPART_GAP - 1);
    w_full    = r_cnt == CNT_W'(DEPTH);
    w_lr_ok   = LR_light inside {GREEN, YELLOW, RED};
    w_hw_ok   = HW_light inside {GREEN, YELLOW, RED};
    w_drop    = car_arrive && !w_dep && w_full;
    w_cnt_nxt = (car_arrive == w_dep) ? r_cnt :
                car_arrive ? (w_full ? r_cnt : r_cnt + 1'b1) : r_cnt - 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      r_state     <= EMPTY;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_depart    <= 1'b0;
      r_overflow  <= 1'b0;
      r_violation <= 1'b0;
    end else begin
      r_state     <= w_cnt_nxt == '0 ? EMPTY : w_green ? FLOWING : WAITING;
      r_cnt       <= w_cnt_nxt;
      r_gap       <= (w_dep || !w_busy) ? '0 : r_gap + 1'b1;
      r_depart    <= w_dep;
      r_overflow  <= r_overflow | w_drop;
      r_violation <= r_violation | !w_lr_ok | !w_hw_ok | (w_green && HW_light == GREEN);
    end
  end
  assign LR_has_Car = r_cnt != '0;
  assign queue_cnt  = r_cnt;
  assign depart     = r_depart;
  assign overflow   = r_overflow;
  assign violation  = r_violation;
endmodule

// File: tb/tb_lr_car_queue.sv
// tb_lr_car_queue: directed scenarios plus random traffic checked against a queue model.
module tb_lr_car_queue;
  localparam int DEPTH = 7;
  localparam int CNT_W = 3;
  localparam int GAP   = 2;
  localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001;
  logic             CLK = 1'b0;
  logic             RESET_n = 1'b0;
  logic             car_arrive = 1'b0;
  logic [2:0]       LR_light = R;
  logic [2:0]       HW_light = G;
  logic             LR_has_Car;
  logic [CNT_W-1:0] queue_cnt;
  logic             depart;
  logic             overflow;
  logic             violation;
  int n_chk = 0;
  int n_fail = 0;
  int m_cnt = 0;
  int m_gap = 0;
  bit m_dep = 0;
  bit m_ovf = 0;
  bit m_viol = 0;

  lr_car_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DEPART_GAP(GAP)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .car_arrive(car_arrive),
    .LR_light(LR_light), .HW_light(HW_light), .LR_has_Car(LR_has_Car),
    .queue_cnt(queue_cnt), .depart(depart), .overflow(overflow), .violation(violation)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: apply inputs, advance the model by the queue rules, compare just after the edge
  task automatic step(input bit rn, input bit arr, input logic [2:0] lr, input logic [2:0] hw);
    @(negedge CLK);
    RESET_n = rn;
    car_arrive = arr;
    LR_light = lr;
    HW_light = hw;
    @(posedge CLK);
    if (!rn) begin
      m_cnt = 0; m_gap = 0; m_dep = 0; m_ovf = 0; m_viol = 0;
    end else begin
      m_dep = 0;
      if (lr == G && m_cnt > 0) begin
        if (m_gap == GAP - 1) begin
          m_dep = 1;
          m_gap = 0;
        end else m_gap++;
      end else m_gap = 0;
      m_cnt = m_cnt + int'(arr) - int'(m_dep);
      if (m_cnt > DEPTH) begin
        m_cnt = DEPTH;
        m_ovf = 1;
      end
      if (!$onehot(lr) || !$onehot(hw) || (lr == G && hw == G)) m_viol = 1;
    end
    #1;
    chk("queue_cnt", int'(queue_cnt), m_cnt);
    chk("LR_has_Car", int'(LR_has_Car), int'(m_cnt != 0));
    chk("depart", int'(depart), int'(m_dep));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("violation", int'(violation), int'(m_viol));
  endtask

  initial begin
    logic [2:0] lr, hw;
    step(0, 0, R, G);
    for (int i = 0; i < 10; i++) step(1, 0, R, G);
    for (int i = 0; i < 9; i++) step(1, 1, R, G);
    chk("sat_cnt", int'(queue_cnt), DEPTH);
    chk("sat_ovf", int'(overflow), 1);
    step(0, 0, R, G);
    for (int i = 0; i < 3; i++) step(1, 1, R, G);
    for (int i = 0; i < 6; i++) step(1, 0, G, R);
    chk("drain_empty", int'(LR_has_Car), 0);
    for (int i = 0; i < 2; i++) step(1, 1, R, G);
    step(1, 0, G, R);
    step(1, 1, G, R);
    chk("simul_cnt", int'(queue_cnt), 2);
    chk("simul_dep", int'(depart), 1);
    step(1, 0, G, R);
    for (int i = 0; i < 4; i++) step(1, 0, Y, R);
    for (int i = 0; i < 3; i++) step(1, 0, G, R);
    step(1, 0, G, G);
    step(1, 0, 3'b011, R);
    step(1, 0, R, G);
    step(1, 0, G, R);
    chk("viol_sticky", int'(violation), 1);
    step(0, 0, R, G);
    for (int i = 0; i < 8; i++) step(1, 1, R, G);
    for (int i = 0; i < 5; i++) step(1, 0, G, R);
    step(0, 1, G, R);
    chk("rst_cnt", int'(queue_cnt), 0);
    chk("rst_ovf", int'(overflow), 0);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: begin lr = R; hw = G; end
        1: begin lr = G; hw = R; end
        2: begin lr = Y; hw = R; end
        3: begin lr = R; hw = Y; end
        default: begin lr = G; hw = R; end
      endcase
      if ($urandom_range(0, 39) == 0) begin
        lr = 3'($urandom);
        hw = 3'($urandom);
      end
      step($urandom_range(0, 59) != 0, 1'($urandom), lr, hw);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lr_car_queue.md
# lr_car_queue

Cycle-accurate model of the local-road side of the intersection: it accepts car-arrival pulses, holds a waiting-car count, and drives `LR_has_Car` into `Traffic_Light_Controller`. It observes the controller's `LR_light`/`HW_light` outputs, releases queued cars only while the local road is green, and flags illegal light combinations. It closes the loop so the controller can be exercised with arrival traffic instead of a fixed `LR_has_Car` bit pattern.

## Interface
- `DEPTH`, 7: maximum queued cars; the count saturates here.
- `CNT_W`, 3: width of `queue_cnt`; must satisfy 2^CNT_W > DEPTH.
- `DEPART_GAP`, 2: number of green, non-empty cycles per departure. Must be ≥1.
- `CLK`  input  1  clock; all state updates on the rising edge.
- `RESET_n`  input  1  reset, synchronous, active-low.
- `car_arrive`  input  1  one car arrives this cycle; sampled at the rising edge.
- `LR_light`  input  3  local-road light from the controller.
- `HW_light`  input  3  highway light from the controller.
- `LR_has_Car`  output  1  queue non-empty; goes to the controller.
- `queue_cnt`  output  CNT_W  current waiting-car count.
- `depart`  output  1  registered one-cycle pulse; one car left at the last edge.
- `overflow`  output  1  sticky; an arrival was dropped at full.
- `violation`  output  1  sticky; an illegal light combination was sampled.

## Operation
- Light encoding, one-hot: Green = 3'b100, Yellow = 3'b010, Red = 3'b001. Any other value is illegal.
- States, registered:
  - EMPTY: `queue_cnt` == 0.
  - WAITING: `queue_cnt` > 0 and `LR_light` ≠ Green.
  - FLOWING: `queue_cnt` > 0 and `LR_light` == Green.
  - Next state is computed from the next `queue_cnt` and the `LR_light` sampled at the same edge.
- Gap counter `gap_cnt`, width ≥ clog2(DEPART_GAP):
  - At each edge in which `LR_light` == Green and `queue_cnt` > 0:
    - If `gap_cnt` == DEPART_GAP-1: a departure occurs, and `gap_cnt` ← 0.
    - Otherwise `gap_cnt` increments.
  - At any edge with `LR_light` ≠ Green or `queue_cnt` == 0, `gap_cnt` ← 0.
  - Yellow releases no cars.
- Count update:
  - Arrival and departure in the same edge: count unchanged. `depart` still pulses.
  - Arrival only: +1. If the count is already DEPTH, it stays DEPTH and `overflow` ← 1.
  - Departure only: −1. A departure requires count > 0, so the count never wraps below 0.
- `LR_has_Car` = (`queue_cnt` ≠ 0), decoded from the registered count. No combinational path from `car_arrive`.
- `violation` ← 1 at any edge where either light is non-one-hot, or both lights are Green. `violation` is diagnostic only and does not block departures.
- Sticky flags clear only on reset.

## Timing
- Reset: at any edge with `RESET_n` = 0, the following all become 0 after that edge, regardless of state or in-flight arrival:
  - `queue_cnt`, `gap_cnt`, `depart`, `overflow`, `violation`, `LR_has_Car`
  - state ← EMPTY
- Arrival latency: `car_arrive` high at edge n gives `queue_cnt`/`LR_has_Car` updated after edge n (1 cycle).
- Departure latency: Green sampled with a non-empty queue at edges k … k+DEPART_GAP−1 → `depart` high for the cycle after edge k+DEPART_GAP−1, and the count is decremented at that same edge.
- Green lost mid-gap: the partial gap is discarded, and counting restarts on the next Green.
- Last car departs and a new arrival occurs at the same edge: the count stays 1 and `LR_has_Car` stays high, with no glitch.

## Test plan
- Reset then idle: `RESET_n` = 0 for 1 edge, lights Red/Green, no arrivals for 10 cycles → `queue_cnt` = 0, `LR_has_Car` = 0, `depart` = 0, flags = 0 throughout.
- Fill and saturate: `LR_light` = Red, `car_arrive` = 1 for 9 edges → count goes 1..7 then holds at 7; `overflow` = 1 after the 8th edge; `LR_has_Car` = 1 after the 1st edge.
- Drain: from count 3, set `LR_light` = Green, `HW_light` = Red, no arrivals → `depart` pulses after edges 2, 4, 6 (counted from the first green edge); count goes 2, 1, 0; `LR_has_Car` falls after edge 6; state goes FLOWING → EMPTY.
- Yellow and simultaneous events:
  - From count 2 with Green, `car_arrive` = 1 on the departure edge → count stays 2 and `depart` = 1.
  - Then switch to Yellow for 4 cycles → no departures; `gap_cnt` resets.
- Violation: drive `HW_light` = `LR_light` = 3'b100 for one edge, then 3'b011 → `violation` = 1 and stays 1 after legal lights resume.
- Reset mid-operation: count 5, `overflow` = 1, Green mid-gap, `RESET_n` = 0 with `car_arrive` = 1 → all outputs 0 after that edge; the arrival is dropped.
